sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_wait_counter.sv | 26 ++
 rtl/sram_controller.sv | 107 ++++++++++
 tb/tb_sram_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit-to-16-bit SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter that times one SRAM half-word phase; tc flags the last cycle.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= 4'(WAIT_CYCLES - 1);
        end else if (enable && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign tc = (count == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage accesses into two 16-bit SRAM phases (LO, HI).
// Define SRAM_WAIT_STATES_EN to stretch each phase to WAIT_CYCLES cycles.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [31:0]                address,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata,
    output logic                       sram_we_n,
    output logic                       sram_oe,
    output logic [1:0]                 fsm_state
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] LO   = ST_LO;
    localparam logic [1:0] HI   = ST_HI;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]  state, next_state;
    logic        req;
    logic        in_phase;
    logic        phase_done;
    logic        write_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [15:0] lo_q;
    logic [31:0] offset;

    assign req      = mem_read | mem_write;
    assign in_phase = (state == LO) || (state == HI);
    assign offset   = address - MEM_BASE;

    // Only word[16:0] reaches the SRAM; higher offset bits wrap away.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

`ifdef SRAM_WAIT_STATES_EN
    logic cnt_load;
    assign cnt_load = ((state == IDLE) && req) || ((state == LO) && phase_done);

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .enable (in_phase),
        .tc     (phase_done)
    );
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
    assign phase_done = 1'b1;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = LO;
            LO:      if (phase_done) next_state = HI;
            HI:      if (phase_done) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Request inputs are latched once; the pipeline may change them mid-access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            write_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                write_q <= mem_write;
                word_q  <= offset[18:2];
                wdata_q <= wdata;
            end
            if (state == LO && phase_done && !write_q) begin
                lo_q <= sram_rdata;
            end
            if (state == HI && phase_done && !write_q) begin
                rdata <= {sram_rdata, lo_q};
            end
        end
    end

    assign ready      = ((state == IDLE) && !req) || (state == DONE);
    assign sram_addr  = {word_q, (state == HI)};
    assign sram_oe    = write_q && in_phase;
    assign sram_we_n  = !(write_q && in_phase);
    assign sram_wdata = !(write_q && in_phase) ? '0 :
                        (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign fsm_state  = state;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural 16-bit SRAM model.
module tb_sram_controller;

`ifdef SRAM_WAIT_STATES_EN
    localparam int PH = 5;
`else
    localparam int PH = 1;
`endif
    localparam int LAT = 2 * PH + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_we_n;
    logic        sram_oe;
    logic [1:0]  fsm_state;

    logic [15:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [15:0] pre_val = '0;
    int          we_cycles = 0;
    int          done_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_rdata = '0;
    int          checks = 0;
    int          errors = 0;

    sram_controller #(.WAIT_CYCLES(5), .MEM_BASE(32'd1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe    (sram_oe),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    assign sram_rdata = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (!sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;
        if (!sram_we_n) we_cycles <= we_cycles + 1;
        if (fsm_state == 2'd3) done_cnt <= done_cnt + 1;
    end

    function automatic logic [7:0] half_idx(input logic [31:0] addr, input logic hi);
        logic [31:0] off;
        off = addr - 32'd1024;
        return {off[8:2], hi};
    endfunction

    task automatic preload(input logic [7:0] idx, input logic [15:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one access in the next cycle and returns at the DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic hold);
        int lat;
        logic [31:0] exp;
        @(negedge clk);
        mem_read = rd; mem_write = wr; address = addr; wdata = wd;
        #1;
        checks++;
        if (ready !== 1'b0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL req_cycle: ready=%b state=%0d, expected ready=0 state=0", ready, fsm_state);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold) begin
                mem_read = 1'b0; mem_write = 1'b0;
                address = $urandom; wdata = $urandom;
            end
        end while (ready !== 1'b1 && lat < 100);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d", lat, LAT);
        end
        exp = exp_q.pop_front();
        checks++;
        if (rdata !== exp) begin
            errors++;
            $display("FAIL rdata @%h: got %h, expected %h", addr, rdata, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || fsm_state !== 2'd0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b state=%0d rdata=%h, expected 1/0/0", ready, fsm_state, rdata);
        end
        checks++;
        if (sram_we_n !== 1'b1 || sram_oe !== 1'b0 || sram_addr !== 18'd0 || sram_wdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_sram: we_n=%b oe=%b addr=%h wdata=%h, expected 1/0/0/0",
                     sram_we_n, sram_oe, sram_addr, sram_wdata);
        end
    endtask

    task automatic test_read();
        preload(8'd0, 16'hBEEF);
        preload(8'd1, 16'hDEAD);
        cur_rdata = 32'hDEADBEEF;
        exp_q.push_back(cur_rdata);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    endtask

    task automatic test_write();
        int we0;
        we0 = we_cycles;
        exp_q.push_back(cur_rdata);
        access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0);
        checks++;
        if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin
            errors++;
            $display("FAIL write_mem: hw2=%h hw3=%h, expected 5678/1234", mem[2], mem[3]);
        end
        checks++;
        if (we_cycles - we0 !== 2 * PH) begin
            errors++;
            $display("FAIL write_we_cycles: got %0d, expected %0d", we_cycles - we0, 2 * PH);
        end
        cur_rdata = 32'h12345678;
        exp_q.push_back(cur_rdata);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
    endtask

    task automatic test_random_reads();
        logic [31:0] addr;
        logic [15:0] lo, hi;
        for (int i = 0; i < 5; i++) begin
            addr = (i == 0) ? 32'd1020 : 32'd1024 + 4 * $urandom_range(4, 60);
            lo = 16'($urandom); hi = 16'($urandom);
            preload(half_idx(addr, 1'b0), lo);
            preload(half_idx(addr, 1'b1), hi);
            cur_rdata = {hi, lo};
            exp_q.push_back(cur_rdata);
            access(1'b1, 1'b0, addr, 32'd0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        preload(8'd20, 16'h1111);
        preload(8'd21, 16'h2222);
        cur_rdata = 32'h22221111;
        exp_q.push_back(cur_rdata);
        access(1'b1, 1'b0, 32'd1064, 32'd0, 1'b1);
        exp_q.push_back(cur_rdata);
        access(1'b1, 1'b0, 32'd1064, 32'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int k, done0;
        k = (PH < 3) ? PH : 3;
        @(negedge clk);
        mem_write = 1'b1; address = 32'd1040; wdata = 32'hA5A55A5A;
        @(negedge clk);
        mem_write = 1'b0;
        repeat (PH + k - 1) @(negedge clk);
        checks++;
        if (fsm_state !== 2'd2 || sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_write_hi: state=%0d we_n=%b, expected 2/0", fsm_state, sram_we_n);
        end
        rst = 1'b1;
        done0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (fsm_state !== 2'd0 || sram_we_n !== 1'b1 || sram_oe !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL abort_state: state=%0d we_n=%b oe=%b rdata=%h, expected 0/1/0/0",
                     fsm_state, sram_we_n, sram_oe, rdata);
        end
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (done_cnt !== done0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d state=%0d, expected 0/0", done_cnt - done0, fsm_state);
        end
        cur_rdata = 32'd0;
    endtask

    task automatic test_priority();
        int we0;
        cur_rdata = {mem[1], mem[0]};
        exp_q.push_back(cur_rdata);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
        we0 = we_cycles;
        exp_q.push_back(cur_rdata);
        access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0);
        checks++;
        if (mem[0] !== 16'hF00D || mem[1] !== 16'hCAFE || we_cycles - we0 !== 2 * PH) begin
            errors++;
            $display("FAIL priority_write: hw0=%h hw1=%h we=%0d, expected F00D/CAFE/%0d",
                     mem[0], mem[1], we_cycles - we0, 2 * PH);
        end
        cur_rdata = 32'hCAFEF00D;
        exp_q.push_back(cur_rdata);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_read();
        test_write();
        test_random_reads();
        test_back_to_back();
        test_reset_mid();
        test_priority();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
